// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_pkg
// Description : Shared types, flag bit positions and OR-tree sizing helpers
//               for the NZCV flag pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package flag_pkg;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int OR_FANIN = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Per-op sideband that travels next to the zero-detect tree.
  typedef struct packed {
    logic valid;
    logic sf;
    logic n;
    logic c;
    logic v;
  } side_t;

  // Width of the vector after lvl OR levels have been applied.
  function automatic int tree_w(input int width, input int lvl);
    int w;
    w = width;
    for (int k = 0; k < lvl; k++) begin
      w = (w + OR_FANIN - 1) / OR_FANIN;
    end
    return w;
  endfunction

  // Number of OR levels needed to reduce width bits to one.
  function automatic int tree_depth(input int width);
    int w;
    int d;
    w = width;
    d = 0;
    for (int k = 0; k < 8; k++) begin
      if (w > 1) begin
        w = (w + OR_FANIN - 1) / OR_FANIN;
        d++;
      end
    end
    return d;
  endfunction

  // Pipeline register r (1..lat) sits after OR level min(2r, depth), so no
  // more than two OR levels ever sit between flops. Returns how many
  // registers follow level lvl.
  function automatic int cuts_at(input int lvl, input int depth, input int lat);
    int cnt;
    cnt = 0;
    for (int r = 1; r <= lat; r++) begin
      if (((2 * r < depth) ? 2 * r : depth) == lvl) cnt++;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/or4_level.sv
`default_nettype none
// ============================================================================
// Module      : or4_level
// Description : One level of the zero-detect OR tree: every group of up to
//               four input bits is reduced to a single output bit.
// Revision    : 1.0 - initial release
// ============================================================================
module or4_level
  import flag_pkg::*;
#(
  parameter int IN_W = 4,
  localparam int OUT_W = (IN_W + OR_FANIN - 1) / OR_FANIN
) (
  input  logic [IN_W-1:0]  i_bits,
  output logic [OUT_W-1:0] o_bits
);

  for (genvar j = 0; j < OUT_W; j++) begin : g_grp
    if (OR_FANIN * j + OR_FANIN <= IN_W) begin : g_full
      assign o_bits[j] = |i_bits[OR_FANIN*j +: OR_FANIN];
    end else begin : g_part
      // Last group is short when IN_W is not a multiple of the fan-in.
      assign o_bits[j] = |i_bits[IN_W-1:OR_FANIN*j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/flag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : flag_pipe
// Description : Pipelined NZCV flag generation for an ALU result, with an
//               architectural flag register, same-cycle forwarding and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_pipe
  import flag_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  output logic             zero,
  output logic [3:0]       flags_q,
  output logic [3:0]       flags_fwd,
  output logic             busy
);

  localparam int DEPTH = tree_depth(WIDTH);

  // Zero-detect OR tree, with pipeline registers inserted between levels.
  for (genvar i = 1; i <= DEPTH; i++) begin : g_lvl
    localparam int IW = tree_w(WIDTH, i - 1);
    localparam int OW = tree_w(WIDTH, i);
    localparam int NC = cuts_at(i, DEPTH, LAT);

    logic [IW-1:0] w_in;
    logic [OW-1:0] w_or;
    logic [OW-1:0] w_stg;

    if (i == 1) begin : g_head
      assign w_in = result;
    end else begin : g_link
      assign w_in = g_lvl[i-1].w_stg;
    end

    or4_level #(.IN_W(IW)) u_or (
      .i_bits (w_in),
      .o_bits (w_or)
    );

    if (NC == 0) begin : g_nc0
      assign w_stg = w_or;
    end else if (NC == 1) begin : g_nc1
      logic [OW-1:0] r_s1;
      // Capture partial OR results at this stage boundary.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_s1 <= '0;
        else          r_s1 <= w_or;
      end
      assign w_stg = r_s1;
    end else begin : g_nc2
      logic [OW-1:0] r_s1;
      logic [OW-1:0] r_s2;
      // Short trees still need LAT stages; the value simply waits here.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_s1 <= '0;
          r_s2 <= '0;
        end else begin
          r_s1 <= w_or;
          r_s2 <= r_s1;
        end
      end
      assign w_stg = r_s2;
    end
  end

  logic  w_zero;
  side_t w_in_side;
  side_t w_out_side;

  assign w_zero          = ~g_lvl[DEPTH].w_stg[0];
  assign w_in_side.valid = in_valid;
  assign w_in_side.sf    = set_flags;
  assign w_in_side.n     = result[WIDTH-1];
  assign w_in_side.c     = carry_in;
  assign w_in_side.v     = ovf_in;

  if (LAT == 0) begin : g_comb
    assign w_out_side = w_in_side;
    assign busy       = 1'b0;
  end else begin : g_stages
    side_t            r_side [LAT];
    logic [LAT-1:0]   w_busy_vec;

    for (genvar s = 0; s < LAT; s++) begin : g_stg
      if (s == 0) begin : g_first
        // Accept a new op every cycle; flush empties the stage.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)   r_side[s] <= '0;
          else if (flush) r_side[s] <= '0;
          else            r_side[s] <= w_in_side;
        end
      end else begin : g_next
        // Advance the sideband one stage; flush empties the stage.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)   r_side[s] <= '0;
          else if (flush) r_side[s] <= '0;
          else            r_side[s] <= r_side[s-1];
        end
      end
      assign w_busy_vec[s] = r_side[s].valid & r_side[s].sf;
    end

    assign w_out_side = r_side[LAT-1];
    assign busy       = |w_busy_vec;
  end

  nzcv_t w_new;
  nzcv_t r_flags;
  logic  w_fire;

  assign out_valid = w_out_side.valid & ~flush & reset_n;
  assign zero      = w_zero;
  assign w_new.n   = w_out_side.n;
  assign w_new.z   = w_zero;
  assign w_new.c   = w_out_side.c;
  assign w_new.v   = w_out_side.v;
  assign w_fire    = out_valid & w_out_side.sf;

  // Architectural NZCV register: written only by a completing set_flags op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_flags <= '0;
    else if (w_fire) r_flags <= w_new;
  end

  assign flags_q   = r_flags;
  assign flags_fwd = w_fire ? w_new : r_flags;

endmodule
`default_nettype wire

// File: tb/tb_flag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_pipe
// Description : Scoreboard bench for flag_pipe over four WIDTH/LAT configs
//               sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_pipe;
  import flag_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] res = '0;
  logic         carry_in = 1'b0;
  logic         ovf_in = 1'b0;
  logic         set_flags = 1'b0;
  logic         flush = 1'b0;

  logic [3:0]   ov;
  logic [3:0]   zr;
  logic [3:0]   bz;
  logic [3:0]   fq [0:3];
  logic [3:0]   ff [0:3];

  always #5 clk = ~clk;

  flag_pipe #(.WIDTH(64), .LAT(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .result(res[63:0]),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov[0]), .zero(zr[0]), .flags_q(fq[0]), .flags_fwd(ff[0]), .busy(bz[0]));
  flag_pipe #(.WIDTH(4), .LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .result(res[3:0]),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov[1]), .zero(zr[1]), .flags_q(fq[1]), .flags_fwd(ff[1]), .busy(bz[1]));
  flag_pipe #(.WIDTH(16), .LAT(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .result(res[15:0]),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov[2]), .zero(zr[2]), .flags_q(fq[2]), .flags_fwd(ff[2]), .busy(bz[2]));
  flag_pipe #(.WIDTH(128), .LAT(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .result(res),
    .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov[3]), .zero(zr[3]), .flags_q(fq[3]), .flags_fwd(ff[3]), .busy(bz[3]));

  function automatic int cfg_w(input int k);
    case (k)
      0:       return 64;
      1:       return 4;
      2:       return 16;
      default: return 128;
    endcase
  endfunction

  function automatic int cfg_lat(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    int         cyc;
    logic       z;
    logic [3:0] nzcv;
    logic       sf;
  } exp_t;

  exp_t       fifo [0:3][0:7];
  int         head [0:3] = '{0, 0, 0, 0};
  int         tail [0:3] = '{0, 0, 0, 0};
  logic [3:0] mflags [0:3] = '{4'h0, 4'h0, 4'h0, 4'h0};
  int         cyc = 0;
  int         kill_cyc = -1;
  bit         stop_req = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: expected response per issued op ------
  task automatic push_all(input logic [127:0] r, input logic c, input logic o, input logic s);
    logic [127:0] mask;
    int           w;
    exp_t         e;
    for (int k = 0; k < 4; k++) begin
      w      = cfg_w(k);
      mask   = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
      e.cyc  = cyc;
      e.z    = ((r & mask) == 128'd0);
      e.nzcv = {r[w-1], e.z, c, o};
      e.sf   = s;
      fifo[k][tail[k] % 8] = e;
      tail[k]++;
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] r, input logic c,
                       input logic o, input logic s, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    res       = r;
    carry_in  = c;
    ovf_in    = o;
    set_flags = s;
    flush     = f;
    if (f) kill_cyc = cyc;
    else if (v && reset_n) push_all(r, c, o, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [127:0] r;
    int           m;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // result=0, carry=1, set_flags -> NZCV 0110
    drive(1'b1, 128'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    // N set but set_flags=0: flags must hold
    drive(1'b1, 128'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // back-to-back set_flags: A (ovf) then B (zero)
    drive(1'b1, 128'h1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 128'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // single-bit sweep and the all-zero case
    for (int k = 0; k < 128; k++) begin
      r = 128'd1 << k;
      drive(1'b1, r, k[0], k[1], k[2], 1'b0);
    end
    drive(1'b1, 128'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // flush with a set_flags op in the first stage
    drive(1'b1, 128'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // randomized traffic including occasional flushes
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(0, 3);
      case (m)
        0:       r = '0;
        1:       r = 128'd1 << $urandom_range(0, 127);
        2:       r = {$urandom(), $urandom(), $urandom(), $urandom()};
        default: r = 128'($urandom_range(1, 255)) << (4 * $urandom_range(0, 30));
      endcase
      drive($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
    end
    // reset asserted between clock edges with ops in flight
    drive(1'b1, 128'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 128'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    set_flags = 1'b0;
    #2;
    reset_n  = 1'b0;
    kill_cyc = cyc;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    res       = 128'h0;
    carry_in  = 1'b1;
    ovf_in    = 1'b0;
    set_flags = 1'b1;
    flush     = 1'b0;
    push_all(res, carry_in, ovf_in, set_flags);
    idle(5);
    stop_req = 1'b1;
  end

  // ---------------- monitor / scoreboard ------------------------------------
  task automatic chk(input string name, input int k, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", name, k, cyc, got, exp);
  endtask

  task automatic check_dut(input int k);
    exp_t       e;
    bit         have;
    bit         exp_ov;
    bit         exp_busy;
    logic [3:0] exp_fwd;
    int         lat;
    lat = cfg_lat(k);
    while (head[k] != tail[k] && fifo[k][head[k] % 8].cyc <= kill_cyc) head[k]++;
    if (!reset_n) mflags[k] = 4'h0;
    have   = (head[k] != tail[k]);
    e      = fifo[k][head[k] % 8];
    exp_ov = have && reset_n && !flush && (e.cyc + lat == cyc);
    exp_fwd = mflags[k];
    if (exp_ov && e.sf) exp_fwd = e.nzcv;
    chk("out_valid", k, {3'b0, ov[k]}, {3'b0, exp_ov});
    if (exp_ov) chk("zero", k, {3'b0, zr[k]}, {3'b0, e.z});
    chk("flags_q", k, fq[k], mflags[k]);
    chk("flags_fwd", k, ff[k], exp_fwd);
    if (!flush) begin
      exp_busy = 1'b0;
      if (lat > 0) begin
        for (int i = head[k]; i < tail[k]; i++) begin
          if (fifo[k][i % 8].sf && fifo[k][i % 8].cyc < cyc) exp_busy = 1'b1;
        end
      end
      chk("busy", k, {3'b0, bz[k]}, {3'b0, exp_busy});
    end
    if (exp_ov) begin
      if (e.sf) mflags[k] = e.nzcv;
      head[k]++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_dut(k);
      if (stop_req) begin
        for (int k = 0; k < 4; k++) chk("drained", k, 4'(tail[k] - head[k]), 4'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
      if (cyc > 5000) begin
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
      end
    end
  end

endmodule
`default_nettype wire
